// File: rtl/stack_frame_register_pkg.sv
// Shared definitions for the stack frame register block.
//   - op_e      : operation codes presented on the op interface (7-15 decode as NOP)
//   - state_e   : sequencer states; every *_MEM state waits for one memory ack
//   - SLOT_BYTES_DEF : default byte step for one push/pop slot
package stack_frame_register_pkg;

  localparam int OP_W           = 4;
  localparam int SLOT_BYTES_DEF = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 4'd0,
    OP_WR_ESP = 4'd1,
    OP_WR_EBP = 4'd2,
    OP_PUSH   = 4'd3,
    OP_POP    = 4'd4,
    OP_ENTER  = 4'd5,
    OP_LEAVE  = 4'd6
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PUSH_MEM  = 3'd1,
    ST_POP_MEM   = 3'd2,
    ST_ENTER_MEM = 3'd3,
    ST_LEAVE_MEM = 3'd4
  } state_e;

endpackage

// File: rtl/stack_frame_register_if.sv
// Bus bundle between the stack frame register and its neighbours.
//   op side  : op, op_valid, write_data (from decode/execute), op_ready (to it)
//   mem side : mem_req, mem_we, mem_addr, mem_wdata (to memory),
//              mem_ack, mem_rdata (from memory)
// Modports:
//   slave  - the stack frame register itself
//   master - the environment (decode stage plus data memory)
interface stack_frame_register_if #(
  parameter int DATA_W = 32
) ();
  import stack_frame_register_pkg::*;

  logic [OP_W-1:0]   op;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] write_data;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  op, op_valid, write_data, mem_ack, mem_rdata,
    output op_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output op, op_valid, write_data, mem_ack, mem_rdata,
    input  op_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/stack_frame_register.sv
// Stack frame register: holds EBP and ESP and sequences push, pop, enter and
// leave against the data memory through a req/ack handshake.
// Ports:
//   clock_5   - sole clock, rising edge
//   reset     - synchronous, active-high; restores all reset values
//   bus       - stack_frame_register_if.slave (op handshake and memory port)
//   ebp, esp  - frame and stack pointers
//   pop_data  - last popped value (held), pop_valid - one-cycle strobe
//   fault     - sticky stack over/underflow flag, cleared only by reset
module stack_frame_register
  import stack_frame_register_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] EBP_RESET   = 32'h0000_0999,
  parameter logic [DATA_W-1:0] ESP_RESET   = 32'h0000_1000,
  parameter logic [DATA_W-1:0] STACK_LIMIT = 32'h0000_0800,
  parameter int                SLOT_BYTES  = SLOT_BYTES_DEF
) (
  input  logic                  clock_5,
  input  logic                  reset,
  stack_frame_register_if.slave bus,
  output logic [DATA_W-1:0]     ebp,
  output logic [DATA_W-1:0]     esp,
  output logic [DATA_W-1:0]     pop_data,
  output logic                  pop_valid,
  output logic                  fault
);

  localparam logic [DATA_W-1:0] SLOT_STEP = DATA_W'(SLOT_BYTES);
  localparam logic [DATA_W-1:0] ZERO_W    = {DATA_W{1'b0}};

  state_e            state_r,     state_nxt_s;
  logic [DATA_W-1:0] ebp_r,       ebp_nxt_s;
  logic [DATA_W-1:0] esp_r,       esp_nxt_s;
  logic              mem_req_r,   mem_req_nxt_s;
  logic              mem_we_r,    mem_we_nxt_s;
  logic [DATA_W-1:0] mem_addr_r,  mem_addr_nxt_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
  logic [DATA_W-1:0] pop_data_r,  pop_data_nxt_s;
  logic              pop_valid_r, pop_valid_nxt_s;
  logic              fault_r,     fault_nxt_s;
  logic              op_ready_r,  op_ready_nxt_s;

  logic [DATA_W-1:0] esp_dec_s;
  logic [DATA_W-1:0] esp_inc_s;
  logic [DATA_W-1:0] ebp_inc_s;
  logic              push_ovf_s;
  logic              pop_unf_s;
  logic              leave_unf_s;
  logic              accept_s;

  // Slot arithmetic and stack bounds comparators (modulo 2^DATA_W)
  always_comb begin
    esp_dec_s   = esp_r - SLOT_STEP;
    esp_inc_s   = esp_r + SLOT_STEP;
    ebp_inc_s   = ebp_r + SLOT_STEP;
    push_ovf_s  = (esp_dec_s < STACK_LIMIT);
    pop_unf_s   = (esp_inc_s > ESP_RESET);
    leave_unf_s = (ebp_inc_s > ESP_RESET);
    accept_s    = bus.op_valid & op_ready_r;
  end

  // Next-state and next-register logic for the op sequencer
  always_comb begin
    state_nxt_s     = state_r;
    ebp_nxt_s       = ebp_r;
    esp_nxt_s       = esp_r;
    mem_req_nxt_s   = mem_req_r;
    mem_we_nxt_s    = mem_we_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    pop_data_nxt_s  = pop_data_r;
    pop_valid_nxt_s = 1'b0;
    fault_nxt_s     = fault_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (bus.op)
            OP_WR_ESP: begin
              esp_nxt_s = bus.write_data;
            end
            OP_WR_EBP: begin
              ebp_nxt_s = bus.write_data;
            end
            OP_PUSH: begin
              if (push_ovf_s) begin
                fault_nxt_s = 1'b1;
              end else begin
                state_nxt_s     = ST_PUSH_MEM;
                mem_req_nxt_s   = 1'b1;
                mem_we_nxt_s    = 1'b1;
                mem_addr_nxt_s  = esp_dec_s;
                mem_wdata_nxt_s = bus.write_data;
              end
            end
            OP_POP: begin
              if (pop_unf_s) begin
                fault_nxt_s = 1'b1;
              end else begin
                state_nxt_s     = ST_POP_MEM;
                mem_req_nxt_s   = 1'b1;
                mem_we_nxt_s    = 1'b0;
                mem_addr_nxt_s  = esp_r;
                mem_wdata_nxt_s = ZERO_W;
              end
            end
            OP_ENTER: begin
              if (push_ovf_s) begin
                fault_nxt_s = 1'b1;
              end else begin
                state_nxt_s     = ST_ENTER_MEM;
                mem_req_nxt_s   = 1'b1;
                mem_we_nxt_s    = 1'b1;
                mem_addr_nxt_s  = esp_dec_s;
                mem_wdata_nxt_s = ebp_r;
              end
            end
            OP_LEAVE: begin
              // Saved frame pointer lives at the current ebp
              if (leave_unf_s) begin
                fault_nxt_s = 1'b1;
              end else begin
                state_nxt_s     = ST_LEAVE_MEM;
                mem_req_nxt_s   = 1'b1;
                mem_we_nxt_s    = 1'b0;
                mem_addr_nxt_s  = ebp_r;
                mem_wdata_nxt_s = ZERO_W;
              end
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_PUSH_MEM: begin
        if (bus.mem_ack) begin
          esp_nxt_s     = esp_dec_s;
          mem_req_nxt_s = 1'b0;
          state_nxt_s   = ST_IDLE;
        end else begin
          state_nxt_s = ST_PUSH_MEM;
        end
      end

      ST_POP_MEM: begin
        if (bus.mem_ack) begin
          pop_data_nxt_s  = bus.mem_rdata;
          pop_valid_nxt_s = 1'b1;
          esp_nxt_s       = esp_inc_s;
          mem_req_nxt_s   = 1'b0;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s = ST_POP_MEM;
        end
      end

      ST_ENTER_MEM: begin
        // New frame pointer is the slot that now holds the old one
        if (bus.mem_ack) begin
          esp_nxt_s     = esp_dec_s;
          ebp_nxt_s     = esp_dec_s;
          mem_req_nxt_s = 1'b0;
          state_nxt_s   = ST_IDLE;
        end else begin
          state_nxt_s = ST_ENTER_MEM;
        end
      end

      ST_LEAVE_MEM: begin
        // ebp is still the pre-LEAVE value here, so ebp + slot is old ebp + slot
        if (bus.mem_ack) begin
          ebp_nxt_s     = bus.mem_rdata;
          esp_nxt_s     = ebp_inc_s;
          mem_req_nxt_s = 1'b0;
          state_nxt_s   = ST_IDLE;
        end else begin
          state_nxt_s = ST_LEAVE_MEM;
        end
      end

      default: begin
        state_nxt_s   = ST_IDLE;
        mem_req_nxt_s = 1'b0;
      end
    endcase

    op_ready_nxt_s = (state_nxt_s == ST_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock_5) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ebp_r       <= EBP_RESET;
      esp_r       <= ESP_RESET;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= ZERO_W;
      mem_wdata_r <= ZERO_W;
      pop_data_r  <= ZERO_W;
      pop_valid_r <= 1'b0;
      fault_r     <= 1'b0;
      op_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      ebp_r       <= ebp_nxt_s;
      esp_r       <= esp_nxt_s;
      mem_req_r   <= mem_req_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      pop_data_r  <= pop_data_nxt_s;
      pop_valid_r <= pop_valid_nxt_s;
      fault_r     <= fault_nxt_s;
      op_ready_r  <= op_ready_nxt_s;
    end
  end

  assign bus.op_ready  = op_ready_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign ebp           = ebp_r;
  assign esp           = esp_r;
  assign pop_data      = pop_data_r;
  assign pop_valid     = pop_valid_r;
  assign fault         = fault_r;

endmodule
